// File: rtl/d_e_pipe_reg_pkg.sv
// Shared constants for the D/E pipeline register: HILO operation encodings and
// the architectural PC values used on reset and on the exception handler flush.
package d_e_pipe_reg_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef enum logic [3:0] {
    HILO_OP_NONE  = 4'd0,
    HILO_OP_MULT  = 4'd1,
    HILO_OP_MULTU = 4'd2,
    HILO_OP_DIV   = 4'd3,
    HILO_OP_DIVU  = 4'd4,
    HILO_OP_MFHI  = 4'd5,
    HILO_OP_MFLO  = 4'd6,
    HILO_OP_MTHI  = 4'd7,
    HILO_OP_MTLO  = 4'd8
  } hilo_op_e;

endpackage

// File: rtl/d_e_pipe_reg_hilo_hazard.sv
// Multiply/divide structural hazard: a HILO-class instruction in D must wait
// while the E-stage HILO unit is busy. Folded into the global stall.
module hilo_hazard
  import d_e_pipe_reg_pkg::*;
#(
  parameter logic [3:0] HILO_NONE = HILO_OP_NONE
) (
  input  logic       stall_in,
  input  logic       hilo_busy,
  input  logic [3:0] hilo_op,
  output logic       stall
);

  logic hilo_haz;

  assign hilo_haz = hilo_busy & (hilo_op != HILO_NONE);
  assign stall    = stall_in | hilo_haz;

endmodule

// File: rtl/d_e_pipe_reg.sv
// Decode-to-execute pipeline register with bubble insertion on stall and
// exception-handler flush on Req. Bubbles keep PC/BD for a precise macro-PC.
module d_e_pipe_reg
  import d_e_pipe_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [3:0]  HILO_NONE  = HILO_OP_NONE
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        StallIn,
  input  logic        E_HILOBusy,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_RS,
  input  logic [31:0] D_RT,
  input  logic [31:0] D_Ext,
  input  logic [3:0]  D_HILOOp,
  input  logic [4:0]  D_ExcCode,
  input  logic        D_BD,
  output logic        Stall,
  output logic [31:0] E_PC,
  output logic [31:0] E_Instr,
  output logic [31:0] E_RS,
  output logic [31:0] E_RT,
  output logic [31:0] E_Ext,
  output logic [3:0]  E_HILOOp,
  output logic [4:0]  E_ExcCode,
  output logic        E_BD
);

  hilo_hazard #(.HILO_NONE(HILO_NONE)) u_hilo_hazard (
    .stall_in (StallIn),
    .hilo_busy(E_HILOBusy),
    .hilo_op  (D_HILOOp),
    .stall    (Stall)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      E_PC      <= RESET_PC;
      E_Instr   <= '0;
      E_RS      <= '0;
      E_RT      <= '0;
      E_Ext     <= '0;
      E_HILOOp  <= HILO_NONE;
      E_ExcCode <= '0;
      E_BD      <= 1'b0;
    end else if (Req) begin
      E_PC      <= HANDLER_PC;
      E_Instr   <= '0;
      E_RS      <= '0;
      E_RT      <= '0;
      E_Ext     <= '0;
      E_HILOOp  <= HILO_NONE;
      E_ExcCode <= '0;
      E_BD      <= 1'b0;
    end else if (Stall) begin
      // Bubble: no op, no HILO issue, but carry PC/BD for interrupt return.
      E_PC      <= D_PC;
      E_Instr   <= '0;
      E_RS      <= '0;
      E_RT      <= '0;
      E_Ext     <= '0;
      E_HILOOp  <= HILO_NONE;
      E_ExcCode <= '0;
      E_BD      <= D_BD;
    end else begin
      E_PC      <= D_PC;
      E_Instr   <= D_Instr;
      E_RS      <= D_RS;
      E_RT      <= D_RT;
      E_Ext     <= D_Ext;
      E_HILOOp  <= D_HILOOp;
      E_ExcCode <= D_ExcCode;
      E_BD      <= D_BD;
    end
  end

endmodule

// File: doc/d_e_pipe_reg.md
Name: d_e_pipe_reg

Overview:
- Decode-to-execute pipeline register that feeds the E stage: it drives the E-stage HILO unit with HILOOp, D1 (rs) and D2 (rt), and also drives the ALU and exception path.
- Folds in the multiply/divide structural hazard. While the E-stage HILO unit reports busy, any HILO-class instruction in D is stalled.
- Supplies load, bubble and flush behaviour, including macro-PC/BD preservation on bubbles and the exception-handler flush on Req.

Parameters:
- RESET_PC, 32'h0000_3000, E_PC value after reset.
- HANDLER_PC, 32'h0000_4180, E_PC value after a Req flush.
- HILO_NONE, 4'd0, HILOOp encoding meaning "no HILO operation" (shared constant).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous reset, active-low (Rst==0 resets on the next rising Clk).
- Req  in  1  interrupt/exception request; flushes this register to the handler state.
- StallIn  in  1  data-hazard stall from the hazard unit (load-use etc.).
- E_HILOBusy  in  1  IsBusy from the E-stage HILO unit (start or busy).
- D_PC  in  32  decode-stage PC.
- D_Instr  in  32  decode-stage instruction.
- D_RS  in  32  forwarded rs value.
- D_RT  in  32  forwarded rt value.
- D_Ext  in  32  extended immediate.
- D_HILOOp  in  4  decoded HILO operation.
- D_ExcCode  in  5  exception code accumulated so far (0 = none).
- D_BD  in  1  instruction is in a branch delay slot.
- Stall  out  1  combined stall to the F/D registers and PC (StallIn | HILO hazard).
- E_PC  out  32  registered PC.
- E_Instr  out  32  registered instruction.
- E_RS  out  32  registered rs value.
- E_RT  out  32  registered rt value.
- E_Ext  out  32  registered immediate.
- E_HILOOp  out  4  registered HILO operation.
- E_ExcCode  out  5  registered exception code.
- E_BD  out  1  registered delay-slot flag.

Behaviour:
- Hazard, combinational: HiloHaz = E_HILOBusy & (D_HILOOp != HILO_NONE). Stall = StallIn | HiloHaz.
- Per-edge priority (highest first): Rst==0 > Req==1 > Stall==1 > normal load.
- Reset: E_PC=RESET_PC; all other outputs 0; E_HILOOp=HILO_NONE.
- Req flush: E_PC=HANDLER_PC; Instr, RS, RT, Ext, ExcCode and BD = 0; HILOOp=HILO_NONE.
- Stall (bubble insertion):
  - E_Instr, E_RS, E_RT and E_Ext = 0.
  - E_HILOOp = HILO_NONE and E_ExcCode = 0.
  - E_PC and E_BD take D_PC and D_BD, so the bubble carries a correct macro-PC for a subsequent interrupt.
- Normal load: every E_* output takes its D_* input on the edge. Latency is exactly 1 cycle.
- Bubbles never present a HILO op, so an E-stage HILO operation cannot be re-issued while the unit is busy.
- Sustained E_HILOBusy with a HILO op in D keeps inserting bubbles every cycle. The first cycle with E_HILOBusy==0 loads the op.
- A non-HILO instruction in D while the unit is busy is not stalled by this block. It passes normally.
- Req takes precedence over a simultaneous stall. The flushed state still shows HILO_NONE.
- Reset while a stall is active: reset values win. Stall remains combinational and reflects inputs only.
- No state beyond the output registers. No counters. Outputs are glitch-free registers. Stall is the only combinational output.

Decomposition:
- HILOOp encodings (HILO_NONE, mult, multu, div, divu, mfhi, mflo, mthi, mtlo), RESET_PC and HANDLER_PC belong in the shared constants file.
- One sub-module is natural: hilo_hazard (the combinational HiloHaz/Stall term), so the hazard unit can reuse it.
- Field registers stay flat in this module.

Test Plan:
- Rst=0 for 1 edge with arbitrary D_* inputs -> E_PC=0x0000_3000, all other outputs 0, E_HILOOp=HILO_NONE.
- Load D_PC=0x3004, D_Instr=0x0109_0018 (mult), D_HILOOp=mult, D_RS=7, D_RT=-3, E_HILOBusy=0 -> next cycle all fields match and Stall=0.
- E_HILOBusy=1 for 5 cycles with D_HILOOp=mflo and D_PC=0x3008 -> Stall=1 each cycle; E_Instr=0, E_HILOOp=NONE, E_PC=0x3008. The cycle after busy drops, E_HILOOp=mflo.
- E_HILOBusy=1 with D_HILOOp=NONE (addu), D_PC=0x300c -> Stall=0 and the instruction is loaded unchanged.
- StallIn=1, Req=1, D_PC=0x3010 -> E_PC=0x4180, E_ExcCode=0, E_BD=0, E_HILOOp=NONE.
- StallIn=1, D_BD=1, D_PC=0x3014, D_ExcCode=4 -> E_PC=0x3014, E_BD=1, E_ExcCode=0, E_Instr=0.
